// File: rtl/frac_baud_gen.sv
// rtl/frac_baud_gen.sv - fractional-divisor UART oversample and baud tick generator
module frac_baud_gen #(
  parameter int INT_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OSR          = 16,
  parameter int DEFAULT_INT  = 78,
  parameter int DEFAULT_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              div_load,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              div_err,
  output logic [INT_W-1:0]  act_int,
  output logic [FRAC_W-1:0] act_frac
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);

  // One extra bit so act_int plus a fractional carry never overflows.
  logic [INT_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic [OS_W-1:0]   os_cnt;

  logic [INT_W-1:0]  shd_int;
  logic [FRAC_W-1:0] shd_frac;
  logic              pending;

  logic [FRAC_W:0]   acc_sum;
  logic [INT_W:0]    period_len;
  logic [INT_W:0]    cnt_inc;
  logic              period_end;
  logic              load_ok;

  // Length of the current period and whether this enabled edge ends it.
  always_comb begin
    acc_sum    = {1'b0, acc} + {1'b0, act_frac};
    period_len = {1'b0, act_int} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};
    cnt_inc    = cnt + {{INT_W{1'b0}}, 1'b1};
    period_end = en && !restart && (cnt_inc == period_len);
    load_ok    = div_load && (div_int >= INT_W'(2));
  end

  // Cycle counter, fractional accumulator, oversample counter and tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      if (restart) begin
        cnt    <= '0;
        acc    <= '0;
        os_cnt <= '0;
      end else if (!en) begin
        // A divisor applied while frozen starts the current period over.
        if (load_ok) begin
          cnt <= '0;
        end
      end else if (period_end) begin
        cnt       <= '0;
        acc       <= acc_sum[FRAC_W-1:0];
        os_tick   <= 1'b1;
        baud_tick <= (os_cnt == OS_LAST);
        os_cnt    <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

  // Divisor shadow, pending transfer at the period boundary and load error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int  <= INT_W'(DEFAULT_INT);
      act_frac <= FRAC_W'(DEFAULT_FRAC);
      shd_int  <= INT_W'(DEFAULT_INT);
      shd_frac <= FRAC_W'(DEFAULT_FRAC);
      pending  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      if (div_load) begin
        div_err <= !load_ok;
      end
      if (restart) begin
        pending <= 1'b0;
        if (load_ok) begin
          act_int  <= div_int;
          act_frac <= div_frac;
        end else if (pending) begin
          act_int  <= shd_int;
          act_frac <= shd_frac;
        end
      end else if (!en) begin
        if (load_ok) begin
          act_int  <= div_int;
          act_frac <= div_frac;
          pending  <= 1'b0;
        end
      end else begin
        // The boundary takes the older pending value; a load in the same
        // cycle becomes the next pending value.
        if (period_end && pending) begin
          act_int  <= shd_int;
          act_frac <= shd_frac;
        end
        if (load_ok) begin
          shd_int  <= div_int;
          shd_frac <= div_frac;
          pending  <= 1'b1;
        end else if (period_end) begin
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_baud_gen.sv
// tb/tb_frac_baud_gen.sv - scoreboard bench for frac_baud_gen
module tb_frac_baud_gen;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              restart;
  logic              div_load;
  logic [INT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              baud_tick;
  logic              div_err;
  logic [INT_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;

  frac_baud_gen #(
    .INT_W(INT_W), .FRAC_W(FRAC_W), .OSR(OSR),
    .DEFAULT_INT(78), .DEFAULT_FRAC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .div_load(div_load), .div_int(div_int), .div_frac(div_frac),
    .os_tick(os_tick), .baud_tick(baud_tick), .div_err(div_err),
    .act_int(act_int), .act_frac(act_frac)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned ivl;
    bit          baud;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned last = 0;
  int unsigned start = 0;
  int          os_idx = 0;
  logic        mark_pend = 1'b0;
  exp_t        e;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int unsigned ivl);
    exp_t x;
    x.ivl  = ivl;
    x.baud = (os_idx == OSR - 1);
    os_idx = (os_idx + 1) % OSR;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_load(input int i, input int f);
    div_int  = INT_W'(i);
    div_frac = FRAC_W'(f);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  task automatic do_restart(input bit with_load, input int i, input int f);
    div_int  = INT_W'(i);
    div_frac = FRAC_W'(f);
    div_load = with_load;
    restart  = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    restart  = 1'b0;
    os_idx   = 0;
  endtask

  // Cycle count and period-start markers (reset, restart, frozen load).
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    mark_pend <= rst | restart | (div_load & ~en & (div_int >= 2));
  end

  // Tick monitor: measure os_tick intervals and compare against the scoreboard.
  always @(negedge clk) begin
    if (mark_pend) last = cyc;
    if (os_tick) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("os_interval", cyc - last, e.ivl);
        check_eq("baud_tick", baud_tick, e.baud);
      end
      last = cyc;
    end else if (baud_tick) begin
      check_eq("baud_without_os", baud_tick, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; restart = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_os_tick", os_tick, 0);
    check_eq("rst_baud_tick", baud_tick, 0);
    check_eq("rst_div_err", div_err, 0);
    check_eq("rst_act_int", act_int, 78);
    check_eq("rst_act_frac", act_frac, 2);

    // Defaults 78+2/16: seven periods of 78 then one of 79
    rst = 1'b0;
    start = cyc;
    os_idx = 0;
    for (int k = 0; k < 16; k++) push_exp((k % 8 == 7) ? 79 : 78);
    wait_drain(1400);
    check_eq("total_16_default", last - start, 1250);

    // 3+4/16 applied with restart: 3,3,3,4 repeating, baud every 52 cycles
    do_restart(1'b1, 3, 4);
    start = cyc;
    check_eq("act_int_3", act_int, 3);
    check_eq("act_frac_4", act_frac, 4);
    for (int k = 0; k < 16; k++) push_exp((k % 4 == 3) ? 4 : 3);
    wait_drain(200);
    check_eq("total_baud_52", last - start, 52);

    // Mid-period load of 10 while running at 20
    do_restart(1'b1, 20, 0);
    push_exp(20); push_exp(20);
    wait_drain(100);
    repeat (7) @(negedge clk);
    push_exp(20); push_exp(10); push_exp(10); push_exp(10);
    do_load(10, 0);
    repeat (3) @(negedge clk);
    check_eq("act_int_before_boundary", act_int, 20);
    wait_drain(100);
    check_eq("act_int_after_boundary", act_int, 10);

    // Rejected load, then a valid load of 5
    repeat (4) @(negedge clk);
    do_load(1, 3);
    check_eq("bad_load_div_err", div_err, 1);
    check_eq("bad_load_act_int", act_int, 10);
    check_eq("bad_load_act_frac", act_frac, 0);
    push_exp(10); push_exp(10);
    wait_drain(100);
    repeat (2) @(negedge clk);
    push_exp(10); push_exp(5); push_exp(5);
    do_load(5, 0);
    check_eq("good_load_div_err", div_err, 0);
    wait_drain(100);
    check_eq("act_int_5", act_int, 5);

    // en low for 7 cycles mid-period at 10+0
    do_restart(1'b1, 10, 0);
    push_exp(10);
    wait_drain(100);
    push_exp(17); push_exp(10);
    repeat (3) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check_eq("os_tick_en_low", os_tick, 0);
    end
    en = 1'b1;
    wait_drain(100);

    // Plain restart: next tick act_int later, os counter back at 0
    do_restart(1'b0, 0, 0);
    for (int k = 0; k < 16; k++) push_exp(10);
    wait_drain(300);

    // Load while frozen applies at once and restarts the period
    en = 1'b0;
    @(negedge clk);
    do_load(7, 0);
    check_eq("frozen_load_act_int", act_int, 7);
    en = 1'b1;
    push_exp(7); push_exp(7);
    wait_drain(100);

    // Reset mid-period with a pending load and a set error flag
    repeat (3) @(negedge clk);
    do_load(30, 0);
    do_load(0, 0);
    check_eq("pre_rst_div_err", div_err, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_os_tick", os_tick, 0);
    check_eq("mid_rst_div_err", div_err, 0);
    check_eq("mid_rst_act_int", act_int, 78);
    check_eq("mid_rst_act_frac", act_frac, 2);
    @(negedge clk);
    rst = 1'b0;
    os_idx = 0;
    push_exp(78); push_exp(78); push_exp(78);
    wait_drain(400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
